// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and parameter defaults for the program-counter fetch unit.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIssue = 2'd0,
    StReq   = 2'd1,
    StValid = 2'd2
  } fetch_state_e;

  localparam int unsigned DefaultAddrW   = 32;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam int unsigned DefaultInc     = 4;

endpackage

// File: rtl/pc_fetch_unit_pc_register.sv
// Program counter flop: synchronous reset, load enable and alignment masking on load.
module pc_fetch_unit_pc_register #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] AlignMask = ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_val & AlignMask;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the PC, runs the imem req/ack handshake and
// presents fetched instructions to decode, dropping any fetch overtaken by a redirect.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DefaultAddrW,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefaultResetPc),
  parameter int unsigned       INC      = DefaultInc
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              sel_dir,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_seq,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int unsigned AlignBits = $clog2(INC);

  fetch_state_e      state_q;
  logic              squash_q;
  logic              imem_req_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic              instr_valid_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              pc_load;

  assign pc_seq = pc + ADDR_W'(INC);

  // A redirect always moves the PC; otherwise only an accepted instruction advances it.
  assign pc_load = sel_dir | ((state_q == StValid) & instr_ready);

  pc_fetch_unit_pc_register #(
    .ADDR_W    (ADDR_W),
    .RESET_PC  (RESET_PC),
    .ALIGN_BITS(AlignBits)
  ) u_pc_register (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_val(next_pc),
    .pc      (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIssue;
      squash_q      <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      unique case (state_q)
        StIssue: begin
          imem_addr_q <= pc;
          // On a redirect, linger so the address is re-latched from the new PC.
          if (!sel_dir) begin
            state_q    <= StReq;
            imem_req_q <= 1'b1;
          end
        end
        StReq: begin
          if (imem_ack) begin
            imem_req_q <= 1'b0;
            squash_q   <= 1'b0;
            if (!squash_q && !sel_dir) begin
              instr_q       <= imem_rdata;
              instr_pc_q    <= imem_addr_q;
              instr_valid_q <= 1'b1;
              state_q       <= StValid;
            end else begin
              state_q <= StIssue;
            end
          end else if (sel_dir) begin
            // The request stays up; its data is discarded when it returns.
            squash_q <= 1'b1;
          end
        end
        StValid: begin
          if (sel_dir || instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= StIssue;
          end
        end
        default: begin
          state_q <= StIssue;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  a_next_pc_seq: assert property (@(posedge clk) disable iff (rst) !sel_dir |-> next_pc == pc_seq);

endmodule
